// File: rtl/dcache_port_arbiter.sv
// Shares the single dcache load/store port between the two EXM pipes, granting slot 0 first,
// and routes each read response back to its issuing pipe through an in-order owner FIFO.
module dcache_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,

  input  logic                           req0_valid,
  output logic                           req0_ready,
  input  logic                           req0_op,
  input  logic [ADDR_W-1:0]              req0_addr,
  input  logic                           req0_uncached,
  input  logic [3:0]                     req0_awstrb,
  input  logic [DATA_W-1:0]              req0_wdata,
  output logic                           req0_rvalid,
  output logic [DATA_W-1:0]              req0_rdata,

  input  logic                           req1_valid,
  output logic                           req1_ready,
  input  logic                           req1_op,
  input  logic [ADDR_W-1:0]              req1_addr,
  input  logic                           req1_uncached,
  input  logic [3:0]                     req1_awstrb,
  input  logic [DATA_W-1:0]              req1_wdata,
  output logic                           req1_rvalid,
  output logic [DATA_W-1:0]              req1_rdata,

  output logic                           dc_valid,
  input  logic                           dc_ready,
  output logic                           dc_op,
  output logic [ADDR_W-1:0]              dc_addr,
  output logic                           dc_uncached,
  output logic [3:0]                     dc_awstrb,
  output logic [DATA_W-1:0]              dc_wdata,
  input  logic                           dc_rvalid,
  input  logic [DATA_W-1:0]              dc_rdata,

  output logic [$clog2(MAX_OUTST):0]     outst_cnt,
  output logic                           err_orphan
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST) + 1;

  logic [MAX_OUTST-1:0] owner_q, owner_d;
  logic [MAX_OUTST-1:0] squash_q, squash_d;
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 orphan_q, orphan_d;

  logic sel, anyValid, selOp, fifoFull, fifoEmpty, block;
  logic accept, push, pop, headLive;

  assign anyValid  = req0_valid | req1_valid;
  assign sel       = ~req0_valid;
  assign selOp     = sel ? req1_op : req0_op;
  assign fifoFull  = (cnt_q == CW'(MAX_OUTST));
  assign fifoEmpty = (cnt_q == '0);
  // Only reads need a FIFO slot, so a full FIFO never stalls a write.
  assign block     = flush | (~selOp & fifoFull);

  assign dc_valid   = anyValid & ~block & ~reset;
  assign req0_ready = ~sel & req0_valid & dc_ready & ~block & ~reset;
  assign req1_ready =  sel & req1_valid & dc_ready & ~block & ~reset;

  assign accept = dc_valid & dc_ready;
  assign push   = accept & ~selOp;
  assign pop    = dc_rvalid & ~fifoEmpty;

  always_comb begin
    dc_op       = 1'b0;
    dc_addr     = '0;
    dc_uncached = 1'b0;
    dc_awstrb   = '0;
    dc_wdata    = '0;
    if (anyValid && !reset) begin
      dc_op       = selOp;
      dc_addr     = sel ? req1_addr     : req0_addr;
      dc_uncached = sel ? req1_uncached : req0_uncached;
      dc_awstrb   = sel ? req1_awstrb   : req0_awstrb;
      dc_wdata    = sel ? req1_wdata    : req0_wdata;
    end
  end

  // A flush in the pop cycle squashes the head too, so it is folded in here directly.
  assign headLive    = pop & ~squash_q[head_q] & ~flush & ~reset;
  assign req0_rvalid = headLive & ~owner_q[head_q];
  assign req1_rvalid = headLive &  owner_q[head_q];
  assign req0_rdata  = dc_rdata;
  assign req1_rdata  = dc_rdata;

  always_comb begin
    owner_d  = owner_q;
    squash_d = squash_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    orphan_d = orphan_q | (dc_rvalid & fifoEmpty);
    if (flush) begin
      squash_d = '1;
    end
    if (push) begin
      owner_d[tail_q]  = sel;
      squash_d[tail_q] = 1'b0;
      tail_d           = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q  <= '0;
      squash_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      squash_q <= squash_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      orphan_q <= orphan_d;
    end
  end

  assign outst_cnt  = cnt_q;
  assign err_orphan = orphan_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: directed scenarios followed by a randomized run
// checked against a queue-based model of outstanding read owners.
module tb_dcache_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int CW = $clog2(MO) + 1;

  logic clock = 1'b0;
  logic reset, flush;
  logic req0_valid, req0_ready, req0_op, req0_uncached, req0_rvalid;
  logic [AW-1:0] req0_addr;
  logic [3:0] req0_awstrb;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic req1_valid, req1_ready, req1_op, req1_uncached, req1_rvalid;
  logic [AW-1:0] req1_addr;
  logic [3:0] req1_awstrb;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic dc_valid, dc_ready, dc_op, dc_uncached, dc_rvalid;
  logic [AW-1:0] dc_addr;
  logic [3:0] dc_awstrb;
  logic [DW-1:0] dc_wdata, dc_rdata;
  logic [CW-1:0] outst_cnt;
  logic err_orphan;

  int passCount = 0;
  int checkCount = 0;

  int ownerQ[$];
  bit squashQ[$];
  bit expOrphan;

  dcache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_addr(req0_addr), .req0_uncached(req0_uncached), .req0_awstrb(req0_awstrb),
    .req0_wdata(req0_wdata), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_addr(req1_addr), .req1_uncached(req1_uncached), .req1_awstrb(req1_awstrb),
    .req1_wdata(req1_wdata), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_op(dc_op), .dc_addr(dc_addr),
    .dc_uncached(dc_uncached), .dc_awstrb(dc_awstrb), .dc_wdata(dc_wdata),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .outst_cnt(outst_cnt), .err_orphan(err_orphan)
  );

  always #5 clock = ~clock;

  // Inputs change 1 time unit after each rising edge; outputs are sampled 3 units later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    flush = 0;
    req0_valid = 0; req0_op = 0; req0_addr = '0; req0_uncached = 0; req0_awstrb = '0; req0_wdata = '0;
    req1_valid = 0; req1_op = 0; req1_addr = '0; req1_uncached = 0; req1_awstrb = '0; req1_wdata = '0;
    dc_ready = 1; dc_rvalid = 0; dc_rdata = '0;
  endtask

  task automatic applyReset();
    clearInputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #3;
  endtask

  task automatic test_reset();
    clearInputs();
    reset = 1;
    req0_valid = 1; req1_valid = 1; dc_rvalid = 1;
    #3;
    checkCount++; if (dc_valid !== 1'b0) $display("[TB] FAIL rst_dc_valid got=%0h exp=0", dc_valid); else passCount++;
    checkCount++; if (req0_ready !== 1'b0) $display("[TB] FAIL rst_req0_ready got=%0h exp=0", req0_ready); else passCount++;
    checkCount++; if (req1_ready !== 1'b0) $display("[TB] FAIL rst_req1_ready got=%0h exp=0", req1_ready); else passCount++;
    checkCount++; if ({req0_rvalid, req1_rvalid} !== 2'b00) $display("[TB] FAIL rst_rvalid got=%0b exp=00", {req0_rvalid, req1_rvalid}); else passCount++;
    checkCount++; if (outst_cnt !== '0) $display("[TB] FAIL rst_outst got=%0d exp=0", outst_cnt); else passCount++;
    checkCount++; if (err_orphan !== 1'b0) $display("[TB] FAIL rst_orphan got=%0h exp=0", err_orphan); else passCount++;
    tick();
    applyReset();
  endtask

  task automatic test_pair_read();
    applyReset();
    tick();
    req0_valid = 1; req0_op = 0; req0_addr = 32'h100;
    req1_valid = 1; req1_op = 0; req1_addr = 32'h104;
    #3;
    checkCount++; if (req0_ready !== 1'b1) $display("[TB] FAIL pair_c0_ready0 got=%0h exp=1", req0_ready); else passCount++;
    checkCount++; if (req1_ready !== 1'b0) $display("[TB] FAIL pair_c0_ready1 got=%0h exp=0", req1_ready); else passCount++;
    checkCount++; if (dc_addr !== 32'h100) $display("[TB] FAIL pair_c0_addr got=%0h exp=100", dc_addr); else passCount++;
    tick();
    req0_valid = 0;
    #3;
    checkCount++; if (req1_ready !== 1'b1) $display("[TB] FAIL pair_c1_ready1 got=%0h exp=1", req1_ready); else passCount++;
    checkCount++; if (dc_addr !== 32'h104) $display("[TB] FAIL pair_c1_addr got=%0h exp=104", dc_addr); else passCount++;
    tick();
    req1_valid = 0; dc_rvalid = 1; dc_rdata = 32'hAAAA;
    #3;
    checkCount++; if (outst_cnt !== 3'd2) $display("[TB] FAIL pair_outst got=%0d exp=2", outst_cnt); else passCount++;
    checkCount++; if ({req0_rvalid, req1_rvalid} !== 2'b10) $display("[TB] FAIL pair_rsp0_rvalid got=%0b exp=10", {req0_rvalid, req1_rvalid}); else passCount++;
    checkCount++; if (req0_rdata !== 32'hAAAA) $display("[TB] FAIL pair_rsp0_data got=%0h exp=aaaa", req0_rdata); else passCount++;
    tick();
    dc_rdata = 32'hBBBB;
    #3;
    checkCount++; if ({req0_rvalid, req1_rvalid} !== 2'b01) $display("[TB] FAIL pair_rsp1_rvalid got=%0b exp=01", {req0_rvalid, req1_rvalid}); else passCount++;
    checkCount++; if (req1_rdata !== 32'hBBBB) $display("[TB] FAIL pair_rsp1_data got=%0h exp=bbbb", req1_rdata); else passCount++;
    tick();
    dc_rvalid = 0;
    #3;
    checkCount++; if (outst_cnt !== 3'd0) $display("[TB] FAIL pair_drained got=%0d exp=0", outst_cnt); else passCount++;
  endtask

  task automatic test_write_only();
    applyReset();
    tick();
    req1_valid = 1; req1_op = 1; req1_awstrb = 4'hF; req1_wdata = 32'h1234; req1_addr = 32'h200;
    #3;
    checkCount++; if (dc_op !== 1'b1) $display("[TB] FAIL wr_op got=%0h exp=1", dc_op); else passCount++;
    checkCount++; if (dc_wdata !== 32'h1234) $display("[TB] FAIL wr_data got=%0h exp=1234", dc_wdata); else passCount++;
    checkCount++; if (dc_addr !== 32'h200) $display("[TB] FAIL wr_addr got=%0h exp=200", dc_addr); else passCount++;
    checkCount++; if (dc_awstrb !== 4'hF) $display("[TB] FAIL wr_strb got=%0h exp=f", dc_awstrb); else passCount++;
    checkCount++; if (req1_ready !== 1'b1) $display("[TB] FAIL wr_ready1 got=%0h exp=1", req1_ready); else passCount++;
    tick();
    clearInputs();
    #3;
    checkCount++; if (outst_cnt !== 3'd0) $display("[TB] FAIL wr_outst got=%0d exp=0", outst_cnt); else passCount++;
  endtask

  task automatic test_full();
    applyReset();
    tick();
    for (int i = 0; i < MO; i++) begin
      req0_valid = 1; req0_op = 0; req0_addr = 32'h400 + 32'(i * 4);
      tick();
    end
    #3;
    checkCount++; if (outst_cnt !== 3'd4) $display("[TB] FAIL full_outst got=%0d exp=4", outst_cnt); else passCount++;
    checkCount++; if (req0_ready !== 1'b0) $display("[TB] FAIL full_read_blocked got=%0h exp=0", req0_ready); else passCount++;
    checkCount++; if (dc_valid !== 1'b0) $display("[TB] FAIL full_dc_valid got=%0h exp=0", dc_valid); else passCount++;
    req0_op = 1; req0_wdata = 32'h77;
    #1;
    checkCount++; if (req0_ready !== 1'b1) $display("[TB] FAIL full_write_ok got=%0h exp=1", req0_ready); else passCount++;
    tick();
    req0_op = 0; dc_rvalid = 1; dc_rdata = 32'h11;
    #3;
    checkCount++; if (req0_ready !== 1'b0) $display("[TB] FAIL full_pop_cycle_ready got=%0h exp=0", req0_ready); else passCount++;
    checkCount++; if (req0_rvalid !== 1'b1) $display("[TB] FAIL full_pop_rvalid got=%0h exp=1", req0_rvalid); else passCount++;
    checkCount++; if (outst_cnt !== 3'd4) $display("[TB] FAIL full_write_no_push got=%0d exp=4", outst_cnt); else passCount++;
    tick();
    dc_rvalid = 0;
    #3;
    checkCount++; if (outst_cnt !== 3'd3) $display("[TB] FAIL full_after_pop got=%0d exp=3", outst_cnt); else passCount++;
    checkCount++; if (req0_ready !== 1'b1) $display("[TB] FAIL full_fifth_accept got=%0h exp=1", req0_ready); else passCount++;
    tick();
    req0_valid = 0;
    #3;
    checkCount++; if (outst_cnt !== 3'd4) $display("[TB] FAIL full_refill got=%0d exp=4", outst_cnt); else passCount++;
  endtask

  task automatic test_flush();
    applyReset();
    tick();
    req0_valid = 1; req0_op = 0; req0_addr = 32'h500;
    tick();
    req0_valid = 0; req1_valid = 1; req1_op = 0; req1_addr = 32'h504;
    tick();
    req1_valid = 0; flush = 1; req0_valid = 1; req0_addr = 32'h508;
    #3;
    checkCount++; if (outst_cnt !== 3'd2) $display("[TB] FAIL fl_outst got=%0d exp=2", outst_cnt); else passCount++;
    checkCount++; if ({dc_valid, req0_ready} !== 2'b00) $display("[TB] FAIL fl_block got=%0b exp=00", {dc_valid, req0_ready}); else passCount++;
    tick();
    flush = 0; req0_valid = 0;
    for (int i = 0; i < 2; i++) begin
      dc_rvalid = 1; dc_rdata = 32'hDEAD0 + 32'(i);
      #3;
      checkCount++; if ({req0_rvalid, req1_rvalid} !== 2'b00) $display("[TB] FAIL fl_squashed_%0d got=%0b exp=00", i, {req0_rvalid, req1_rvalid}); else passCount++;
      tick();
    end
    dc_rvalid = 0;
    #3;
    checkCount++; if (outst_cnt !== 3'd0) $display("[TB] FAIL fl_drained got=%0d exp=0", outst_cnt); else passCount++;
    tick();
    req1_valid = 1; req1_op = 0; req1_addr = 32'h600;
    tick();
    req1_valid = 0; dc_rvalid = 1; dc_rdata = 32'hCAFE;
    #3;
    checkCount++; if ({req0_rvalid, req1_rvalid} !== 2'b01) $display("[TB] FAIL fl_new_rvalid got=%0b exp=01", {req0_rvalid, req1_rvalid}); else passCount++;
    checkCount++; if (req1_rdata !== 32'hCAFE) $display("[TB] FAIL fl_new_data got=%0h exp=cafe", req1_rdata); else passCount++;
    tick();
    dc_rvalid = 0;
  endtask

  task automatic test_orphan();
    applyReset();
    tick();
    #3;
    checkCount++; if (err_orphan !== 1'b0) $display("[TB] FAIL orph_pre got=%0h exp=0", err_orphan); else passCount++;
    tick();
    dc_rvalid = 1; dc_rdata = 32'h99;
    #3;
    checkCount++; if ({req0_rvalid, req1_rvalid} !== 2'b00) $display("[TB] FAIL orph_rvalid got=%0b exp=00", {req0_rvalid, req1_rvalid}); else passCount++;
    tick();
    dc_rvalid = 0;
    tick(); tick();
    #3;
    checkCount++; if (err_orphan !== 1'b1) $display("[TB] FAIL orph_sticky got=%0h exp=1", err_orphan); else passCount++;
    checkCount++; if (outst_cnt !== 3'd0) $display("[TB] FAIL orph_outst got=%0d exp=0", outst_cnt); else passCount++;
  endtask

  task automatic test_reset_midflight();
    applyReset();
    tick();
    req0_valid = 1; req0_op = 0;
    for (int i = 0; i < 3; i++) begin
      req0_addr = 32'h700 + 32'(i * 4);
      tick();
    end
    #3;
    checkCount++; if (outst_cnt !== 3'd3) $display("[TB] FAIL mid_pre got=%0d exp=3", outst_cnt); else passCount++;
    #1;
    reset = 1; dc_rvalid = 1;
    #1;
    checkCount++; if (outst_cnt !== 3'd0) $display("[TB] FAIL mid_async_outst got=%0d exp=0", outst_cnt); else passCount++;
    checkCount++; if ({dc_valid, req0_ready, req1_ready, req0_rvalid, req1_rvalid} !== 5'b0) $display("[TB] FAIL mid_outputs got=%0b exp=00000", {dc_valid, req0_ready, req1_ready, req0_rvalid, req1_rvalid}); else passCount++;
    tick();
    clearInputs();
    reset = 0;
    tick();
    req1_valid = 1; req1_op = 0; req1_addr = 32'h800;
    #3;
    checkCount++; if (req1_ready !== 1'b1) $display("[TB] FAIL mid_post_ready got=%0h exp=1", req1_ready); else passCount++;
    tick();
    req1_valid = 0; dc_rvalid = 1; dc_rdata = 32'h5555;
    #3;
    checkCount++; if ({req0_rvalid, req1_rvalid} !== 2'b01) $display("[TB] FAIL mid_post_rvalid got=%0b exp=01", {req0_rvalid, req1_rvalid}); else passCount++;
    checkCount++; if (req1_rdata !== 32'h5555) $display("[TB] FAIL mid_post_data got=%0h exp=5555", req1_rdata); else passCount++;
    tick();
    dc_rvalid = 0;
  endtask

  // The model holds one queue entry per read awaiting data: who issued it and whether a flush killed it.
  task automatic test_random();
    bit expSel, expOp, expBlock, expDcValid, expR0, expR1, expRv0, expRv1, expPop, expPush;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    applyReset();
    tick();
    ownerQ.delete();
    squashQ.delete();
    expOrphan = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      req0_valid = ($urandom_range(0, 2) == 0);
      req1_valid = ($urandom_range(0, 1) == 0);
      req0_op = $urandom_range(0, 3) == 0; req1_op = $urandom_range(0, 3) == 0;
      req0_addr = $urandom; req1_addr = $urandom;
      req0_wdata = $urandom; req1_wdata = $urandom;
      req0_uncached = $urandom_range(0, 1) == 1; req1_uncached = $urandom_range(0, 1) == 1;
      req0_awstrb = 4'($urandom); req1_awstrb = 4'($urandom);
      dc_ready = ($urandom_range(0, 3) != 0);
      dc_rvalid = ($urandom_range(0, 9) < 4);
      dc_rdata = $urandom;
      flush = ($urandom_range(0, 19) == 0);
      #3;
      expSel = !req0_valid;
      expOp = expSel ? req1_op : req0_op;
      expBlock = flush || (!expOp && ownerQ.size() == MO);
      expDcValid = (req0_valid || req1_valid) && !expBlock;
      expR0 = req0_valid && dc_ready && !expBlock;
      expR1 = !req0_valid && req1_valid && dc_ready && !expBlock;
      expAddr = (req0_valid || req1_valid) ? (expSel ? req1_addr : req0_addr) : '0;
      expWdata = (req0_valid || req1_valid) ? (expSel ? req1_wdata : req0_wdata) : '0;
      expPop = dc_rvalid && ownerQ.size() > 0;
      expRv0 = expPop && !flush && !squashQ[0] && ownerQ[0] == 0;
      expRv1 = expPop && !flush && !squashQ[0] && ownerQ[0] == 1;
      expPush = expDcValid && dc_ready && !expOp;
      checkCount++; if (dc_valid !== expDcValid) $display("[TB] FAIL rnd%0d_dc_valid got=%0h exp=%0h", cyc, dc_valid, expDcValid); else passCount++;
      checkCount++; if ({req0_ready, req1_ready} !== {expR0, expR1}) $display("[TB] FAIL rnd%0d_ready got=%0b exp=%0b", cyc, {req0_ready, req1_ready}, {expR0, expR1}); else passCount++;
      checkCount++; if ({req0_rvalid, req1_rvalid} !== {expRv0, expRv1}) $display("[TB] FAIL rnd%0d_rvalid got=%0b exp=%0b", cyc, {req0_rvalid, req1_rvalid}, {expRv0, expRv1}); else passCount++;
      checkCount++; if ({dc_addr, dc_wdata} !== {expAddr, expWdata}) $display("[TB] FAIL rnd%0d_fields got=%0h/%0h exp=%0h/%0h", cyc, dc_addr, dc_wdata, expAddr, expWdata); else passCount++;
      checkCount++; if (req0_rdata !== dc_rdata || req1_rdata !== dc_rdata) $display("[TB] FAIL rnd%0d_rdata got=%0h/%0h exp=%0h", cyc, req0_rdata, req1_rdata, dc_rdata); else passCount++;
      checkCount++; if (outst_cnt !== CW'(ownerQ.size())) $display("[TB] FAIL rnd%0d_outst got=%0d exp=%0d", cyc, outst_cnt, ownerQ.size()); else passCount++;
      checkCount++; if (err_orphan !== expOrphan) $display("[TB] FAIL rnd%0d_orphan got=%0h exp=%0h", cyc, err_orphan, expOrphan); else passCount++;
      if (dc_rvalid && ownerQ.size() == 0) expOrphan = 1;
      if (flush) foreach (squashQ[k]) squashQ[k] = 1;
      if (expPop) begin
        void'(ownerQ.pop_front());
        void'(squashQ.pop_front());
      end
      if (expPush) begin
        ownerQ.push_back(int'(expSel));
        squashQ.push_back(1'b0);
      end
      tick();
    end
    clearInputs();
  endtask

  initial begin
    clearInputs();
    reset = 0;
    #1;
    test_reset();
    test_pair_read();
    test_write_only();
    test_full();
    test_flush();
    test_orphan();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
